// File: rtl/l2_arb_pkg.sv
// Shared types and constants for the L2 port arbiter.
package l2_arb_pkg;

  // Arbiter FSM states: free, owned for a plain access, locked after a write-back.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    OWN_I  = 3'd1,
    OWN_D  = 3'd2,
    LOCK_I = 3'd3,
    LOCK_D = 3'd4
  } arb_state_t;

  // Current owner of the L2 port (also exported as a debug output).
  typedef enum logic [1:0] {
    OWNER_NONE = 2'b00,
    OWNER_I    = 2'b01,
    OWNER_D    = 2'b10
  } owner_t;

  // Arbitration modes.
  localparam int ARB_RR      = 0;
  localparam int ARB_FIXED_D = 1;

  // Encoding of the last_grant register.
  localparam logic LG_I = 1'b0;
  localparam logic LG_D = 1'b1;

  // Default cache line geometry.
  localparam int BLOCKS_DEF = 4;
  typedef logic [BLOCKS_DEF*32-1:0] line_block_t;

endpackage

// File: rtl/l2_arb_pick.sv
// Combinational winner selection used while the L2 port is free.
module l2_arb_pick
  import l2_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  logic   last_grant,
  input  logic   mode,
  output owner_t winner
);

  // Sole requester wins; on a conflict either D (fixed mode) or the side not served last.
  always_comb begin
    winner = OWNER_NONE;
    if (i_req && d_req) begin
      if (mode) begin
        winner = OWNER_D;
      end else if (last_grant == LG_D) begin
        winner = OWNER_I;
      end else begin
        winner = OWNER_D;
      end
    end else if (i_req) begin
      winner = OWNER_I;
    end else if (d_req) begin
      winner = OWNER_D;
    end else begin
      winner = OWNER_NONE;
    end
  end

endmodule

// File: rtl/l2_port_arbiter.sv
// Shares one L2 port between the I-cache and D-cache miss engines.
// The granted cache is forwarded with no added latency; a write-back keeps
// the port locked so the following refill cannot be interleaved.
module l2_port_arbiter
  import l2_arb_pkg::*;
#(
  parameter int BLOCKS      = 4,
  parameter int ARB_MODE    = 0,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_mem_req,
  input  logic                i_mem_we,
  input  logic [31:0]         i_mem_addr,
  input  logic [BLOCKS*32-1:0] i_mem_write_block,
  output logic [BLOCKS*32-1:0] i_mem_read_block,
  output logic                i_mem_miss,
  input  logic                d_mem_req,
  input  logic                d_mem_we,
  input  logic [31:0]         d_mem_addr,
  input  logic [BLOCKS*32-1:0] d_mem_write_block,
  output logic [BLOCKS*32-1:0] d_mem_read_block,
  output logic                d_mem_miss,
  output logic                l2_req,
  output logic                l2_we,
  output logic [31:0]         l2_addr,
  output logic [BLOCKS*32-1:0] l2_write_block,
  input  logic [BLOCKS*32-1:0] l2_read_block,
  input  logic                l2_miss,
  output logic [1:0]          owner,
  output logic [31:0]         conflict_cnt
);

  localparam int HOLD_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(HOLD_CYCLES);
  localparam logic MODE_BIT = (ARB_MODE == ARB_FIXED_D) ? 1'b1 : 1'b0;

  arb_state_t        state_r, state_n;
  logic              last_grant_r, last_grant_n;
  logic [HOLD_W-1:0] hold_r, hold_n;
  logic [HOLD_W-1:0] hold_inc_s;
  logic [31:0]       conflict_r;

  owner_t winner_s;
  owner_t owner_s;
  logic   own_req_s;
  logic   own_we_s;
  logic   is_lock_s;
  logic   own_grant_s;
  arb_state_t own_state_s;
  arb_state_t lock_state_s;

  l2_arb_pick u_pick (
    .i_req      (i_mem_req),
    .d_req      (d_mem_req),
    .last_grant (last_grant_r),
    .mode       (MODE_BIT),
    .winner     (winner_s)
  );

  // Effective owner: the free-port winner acts in the same cycle; nothing is owned in reset.
  always_comb begin
    owner_s = OWNER_NONE;
    if (!reset) begin
      owner_s = OWNER_NONE;
    end else begin
      case (state_r)
        IDLE:          owner_s = winner_s;
        OWN_I, LOCK_I: owner_s = OWNER_I;
        OWN_D, LOCK_D: owner_s = OWNER_D;
        default:       owner_s = OWNER_NONE;
      endcase
    end
  end

  // Forward the owner's request to L2 and generate both stall signals.
  always_comb begin
    l2_req         = 1'b0;
    l2_we          = 1'b0;
    l2_addr        = 32'h0000_0000;
    l2_write_block = '0;
    i_mem_miss     = 1'b0;
    d_mem_miss     = 1'b0;
    own_req_s      = 1'b0;
    own_we_s       = 1'b0;
    case (owner_s)
      OWNER_I: begin
        l2_req         = i_mem_req;
        l2_we          = i_mem_we;
        l2_addr        = i_mem_addr;
        l2_write_block = i_mem_write_block;
        i_mem_miss     = l2_miss;
        d_mem_miss     = d_mem_req;
        own_req_s      = i_mem_req;
        own_we_s       = i_mem_we;
      end
      OWNER_D: begin
        l2_req         = d_mem_req;
        l2_we          = d_mem_we;
        l2_addr        = d_mem_addr;
        l2_write_block = d_mem_write_block;
        i_mem_miss     = i_mem_req;
        d_mem_miss     = l2_miss;
        own_req_s      = d_mem_req;
        own_we_s       = d_mem_we;
      end
      default: begin
        l2_req     = 1'b0;
        i_mem_miss = 1'b0;
        d_mem_miss = 1'b0;
      end
    endcase
  end

  assign i_mem_read_block = l2_read_block;
  assign d_mem_read_block = l2_read_block;
  assign owner            = owner_s;
  assign conflict_cnt     = conflict_r;
  assign hold_inc_s       = hold_r + {{(HOLD_W-1){1'b0}}, 1'b1};

  // Per-owner helper values used by the next-state logic.
  always_comb begin
    is_lock_s    = (state_r == LOCK_I) || (state_r == LOCK_D);
    own_grant_s  = (owner_s == OWNER_D) ? LG_D : LG_I;
    own_state_s  = (owner_s == OWNER_D) ? OWN_D : OWN_I;
    lock_state_s = (owner_s == OWNER_D) ? LOCK_D : LOCK_I;
  end

  // Next-state logic: completion, write-back lock, idle-owner hold timeout.
  always_comb begin
    state_n      = state_r;
    last_grant_n = last_grant_r;
    hold_n       = hold_r;
    if (owner_s == OWNER_NONE) begin
      state_n = IDLE;
      hold_n  = '0;
    end else if (!own_req_s) begin
      if (is_lock_s) begin
        if (hold_inc_s >= HOLD_LIMIT) begin
          state_n      = IDLE;
          last_grant_n = own_grant_s;
          hold_n       = '0;
        end else begin
          hold_n = hold_inc_s;
        end
      end else begin
        state_n = IDLE;
        hold_n  = '0;
      end
    end else if (!l2_miss) begin
      if (own_we_s) begin
        state_n = lock_state_s;
        hold_n  = '0;
      end else begin
        state_n      = IDLE;
        last_grant_n = own_grant_s;
        hold_n       = '0;
      end
    end else begin
      if (state_r == IDLE) begin
        state_n = own_state_s;
      end else begin
        state_n = state_r;
      end
      hold_n = '0;
    end
  end

  // FSM state, fairness pointer and hold counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      last_grant_r <= LG_D;
      hold_r       <= '0;
    end else begin
      state_r      <= state_n;
      last_grant_r <= last_grant_n;
      hold_r       <= hold_n;
    end
  end

  // Saturating count of cycles where both caches request at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      conflict_r <= 32'h0000_0000;
    end else if (i_mem_req && d_mem_req && (conflict_r != 32'hFFFF_FFFF)) begin
      conflict_r <= conflict_r + 32'h0000_0001;
    end else begin
      conflict_r <= conflict_r;
    end
  end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed self-checking bench for l2_port_arbiter (round-robin and fixed-D instances).
module tb_l2_port_arbiter;

  localparam int BLOCKS = 4;
  localparam int LW = BLOCKS*32;

  logic clock;
  logic reset;
  logic i_req, i_we, d_req, d_we, l2_miss;
  logic [31:0] i_addr, d_addr;
  logic [LW-1:0] i_wb, d_wb, l2_rd;

  logic [LW-1:0] rr_i_rd, rr_d_rd, rr_l2_wb, fx_i_rd, fx_d_rd, fx_l2_wb;
  logic rr_i_miss, rr_d_miss, rr_l2_req, rr_l2_we;
  logic fx_i_miss, fx_d_miss, fx_l2_req, fx_l2_we;
  logic [31:0] rr_l2_addr, rr_cnt, fx_l2_addr, fx_cnt;
  logic [1:0] rr_owner, fx_owner;

  int checks;
  int failures;

  l2_port_arbiter #(.BLOCKS(BLOCKS), .ARB_MODE(0), .HOLD_CYCLES(2)) dut_rr (
    .clock(clock), .reset(reset),
    .i_mem_req(i_req), .i_mem_we(i_we), .i_mem_addr(i_addr), .i_mem_write_block(i_wb),
    .i_mem_read_block(rr_i_rd), .i_mem_miss(rr_i_miss),
    .d_mem_req(d_req), .d_mem_we(d_we), .d_mem_addr(d_addr), .d_mem_write_block(d_wb),
    .d_mem_read_block(rr_d_rd), .d_mem_miss(rr_d_miss),
    .l2_req(rr_l2_req), .l2_we(rr_l2_we), .l2_addr(rr_l2_addr), .l2_write_block(rr_l2_wb),
    .l2_read_block(l2_rd), .l2_miss(l2_miss), .owner(rr_owner), .conflict_cnt(rr_cnt)
  );

  l2_port_arbiter #(.BLOCKS(BLOCKS), .ARB_MODE(1), .HOLD_CYCLES(2)) dut_fx (
    .clock(clock), .reset(reset),
    .i_mem_req(i_req), .i_mem_we(i_we), .i_mem_addr(i_addr), .i_mem_write_block(i_wb),
    .i_mem_read_block(fx_i_rd), .i_mem_miss(fx_i_miss),
    .d_mem_req(d_req), .d_mem_we(d_we), .d_mem_addr(d_addr), .d_mem_write_block(d_wb),
    .d_mem_read_block(fx_d_rd), .d_mem_miss(fx_d_miss),
    .l2_req(fx_l2_req), .l2_we(fx_l2_we), .l2_addr(fx_l2_addr), .l2_write_block(fx_l2_wb),
    .l2_read_block(l2_rd), .l2_miss(l2_miss), .owner(fx_owner), .conflict_cnt(fx_cnt)
  );

  // Free-running clock, 10 time-unit period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    i_req = 1'b0; i_we = 1'b0; i_addr = 32'h0; i_wb = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wb = '0;
    l2_miss = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    i_req = 1'b1; i_addr = 32'h0000_0ABC; d_req = 1'b1; d_addr = 32'h0000_0DEF;
    tick();
    #1;
    checks++; if (rr_l2_req !== 1'b0) begin failures++; $display("FAIL rst_l2_req got=%0h exp=0", rr_l2_req); end
    checks++; if (rr_l2_addr !== 32'h0) begin failures++; $display("FAIL rst_l2_addr got=%0h exp=0", rr_l2_addr); end
    checks++; if (rr_owner !== 2'b00) begin failures++; $display("FAIL rst_owner got=%0h exp=0", rr_owner); end
    checks++; if (rr_cnt !== 32'h0) begin failures++; $display("FAIL rst_cnt got=%0h exp=0", rr_cnt); end
    checks++; if ({rr_i_miss, rr_d_miss} !== 2'b00) begin failures++; $display("FAIL rst_miss got=%0h exp=0", {rr_i_miss, rr_d_miss}); end
    checks++; if (fx_owner !== 2'b00) begin failures++; $display("FAIL rst_fx_owner got=%0h exp=0", fx_owner); end
    do_reset();
  endtask

  task automatic test_i_only();
    i_req = 1'b1; i_addr = 32'h1000_0040; l2_miss = 1'b1;
    l2_rd = {32'hDEAD_0003, 32'hBEEF_0002, 32'hCAFE_0001, 32'hF00D_0000};
    #1;
    checks++; if (rr_l2_addr !== 32'h1000_0040) begin failures++; $display("FAIL i_only_addr got=%0h exp=10000040", rr_l2_addr); end
    checks++; if (rr_owner !== 2'b01) begin failures++; $display("FAIL i_only_owner0 got=%0h exp=1", rr_owner); end
    checks++; if (rr_l2_req !== 1'b1) begin failures++; $display("FAIL i_only_req got=%0h exp=1", rr_l2_req); end
    checks++; if ({rr_i_miss, rr_d_miss} !== 2'b10) begin failures++; $display("FAIL i_only_miss0 got=%0h exp=2", {rr_i_miss, rr_d_miss}); end
    checks++; if (rr_d_rd !== {32'hDEAD_0003, 32'hBEEF_0002, 32'hCAFE_0001, 32'hF00D_0000}) begin failures++; $display("FAIL bcast_d_rd got=%0h", rr_d_rd); end
    checks++; if (rr_i_rd !== {32'hDEAD_0003, 32'hBEEF_0002, 32'hCAFE_0001, 32'hF00D_0000}) begin failures++; $display("FAIL bcast_i_rd got=%0h", rr_i_rd); end
    tick(); #1;
    checks++; if ({rr_i_miss, rr_owner} !== 3'b101) begin failures++; $display("FAIL i_only_c1 got=%0h exp=5", {rr_i_miss, rr_owner}); end
    tick(); #1;
    checks++; if ({rr_i_miss, rr_owner} !== 3'b101) begin failures++; $display("FAIL i_only_c2 got=%0h exp=5", {rr_i_miss, rr_owner}); end
    tick(); l2_miss = 1'b0; #1;
    checks++; if ({rr_i_miss, rr_d_miss} !== 2'b00) begin failures++; $display("FAIL i_only_c3_miss got=%0h exp=0", {rr_i_miss, rr_d_miss}); end
    tick(); i_req = 1'b0; #1;
    checks++; if (rr_owner !== 2'b00) begin failures++; $display("FAIL i_only_after_owner got=%0h exp=0", rr_owner); end
    // Combinational probe: last_grant is now I, so a conflict goes to D.
    i_req = 1'b1; d_req = 1'b1; d_addr = 32'h2000_0080; #1;
    checks++; if (rr_owner !== 2'b10) begin failures++; $display("FAIL i_only_last_grant got=%0h exp=2", rr_owner); end
    i_req = 1'b0; d_req = 1'b0; #1;
  endtask

  task automatic test_rr_conflict();
    do_reset();
    i_req = 1'b1; i_addr = 32'h0000_0100; d_req = 1'b1; d_addr = 32'h0000_0200; l2_miss = 1'b1; #1;
    checks++; if (rr_owner !== 2'b01) begin failures++; $display("FAIL rr_first_owner got=%0h exp=1", rr_owner); end
    checks++; if (rr_l2_addr !== 32'h0000_0100) begin failures++; $display("FAIL rr_first_addr got=%0h exp=100", rr_l2_addr); end
    checks++; if ({rr_i_miss, rr_d_miss} !== 2'b11) begin failures++; $display("FAIL rr_c0_miss got=%0h exp=3", {rr_i_miss, rr_d_miss}); end
    tick(); l2_miss = 1'b0; #1;
    checks++; if ({rr_i_miss, rr_d_miss} !== 2'b01) begin failures++; $display("FAIL rr_c1_miss got=%0h exp=1", {rr_i_miss, rr_d_miss}); end
    tick(); i_addr = 32'h0000_0140; l2_miss = 1'b1; #1;
    checks++; if (rr_owner !== 2'b10) begin failures++; $display("FAIL rr_repeat_owner got=%0h exp=2", rr_owner); end
    checks++; if (rr_l2_addr !== 32'h0000_0200) begin failures++; $display("FAIL rr_repeat_addr got=%0h exp=200", rr_l2_addr); end
    checks++; if (rr_cnt !== 32'd2) begin failures++; $display("FAIL rr_cnt2 got=%0d exp=2", rr_cnt); end
    tick(); l2_miss = 1'b0; #1;
    checks++; if ({rr_i_miss, rr_d_miss} !== 2'b10) begin failures++; $display("FAIL rr_c3_miss got=%0h exp=2", {rr_i_miss, rr_d_miss}); end
    tick(); d_req = 1'b0; #1;
    checks++; if (rr_owner !== 2'b01) begin failures++; $display("FAIL rr_c4_owner got=%0h exp=1", rr_owner); end
    checks++; if (rr_cnt !== 32'd4) begin failures++; $display("FAIL rr_cnt4 got=%0d exp=4", rr_cnt); end
    tick(); i_req = 1'b0; #1;
  endtask

  task automatic test_fixed_conflict();
    do_reset();
    i_req = 1'b1; i_addr = 32'h0000_0100; d_req = 1'b1; d_addr = 32'h0000_0200; l2_miss = 1'b1; #1;
    checks++; if (fx_owner !== 2'b10) begin failures++; $display("FAIL fx_first_owner got=%0h exp=2", fx_owner); end
    checks++; if ({fx_i_miss, fx_d_miss} !== 2'b11) begin failures++; $display("FAIL fx_c0_miss got=%0h exp=3", {fx_i_miss, fx_d_miss}); end
    tick(); l2_miss = 1'b0; #1;
    tick(); d_addr = 32'h0000_0240; l2_miss = 1'b1; #1;
    checks++; if (fx_owner !== 2'b10) begin failures++; $display("FAIL fx_repeat_owner got=%0h exp=2", fx_owner); end
    checks++; if (fx_l2_addr !== 32'h0000_0240) begin failures++; $display("FAIL fx_repeat_addr got=%0h exp=240", fx_l2_addr); end
    checks++; if (fx_i_miss !== 1'b1) begin failures++; $display("FAIL fx_i_stall got=%0h exp=1", fx_i_miss); end
    tick(); l2_miss = 1'b0; #1;
    tick(); d_req = 1'b0; #1;
    checks++; if (fx_owner !== 2'b01) begin failures++; $display("FAIL fx_i_after got=%0h exp=1", fx_owner); end
    tick(); i_req = 1'b0; #1;
  endtask

  task automatic test_writeback_lock();
    do_reset();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_1F40;
    d_wb = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}; l2_miss = 1'b1; #1;
    checks++; if ({rr_owner, rr_l2_we} !== 3'b101) begin failures++; $display("FAIL wb_owner_we got=%0h exp=5", {rr_owner, rr_l2_we}); end
    checks++; if (rr_l2_addr !== 32'h0000_1F40) begin failures++; $display("FAIL wb_addr got=%0h exp=1f40", rr_l2_addr); end
    checks++; if (rr_l2_wb !== {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}) begin failures++; $display("FAIL wb_data got=%0h", rr_l2_wb); end
    tick(); l2_miss = 1'b0; #1;
    checks++; if (rr_d_miss !== 1'b0) begin failures++; $display("FAIL wb_done_miss got=%0h exp=0", rr_d_miss); end
    tick(); d_req = 1'b0; d_we = 1'b0; i_req = 1'b1; i_addr = 32'h0000_0300; l2_miss = 1'b1; #1;
    checks++; if ({rr_owner, rr_l2_req, rr_i_miss} !== 4'b1001) begin failures++; $display("FAIL wb_gap got=%0h exp=9", {rr_owner, rr_l2_req, rr_i_miss}); end
    tick(); d_req = 1'b1; d_addr = 32'h0000_0F40; #1;
    checks++; if ({rr_owner, rr_l2_we} !== 3'b100) begin failures++; $display("FAIL refill_owner got=%0h exp=4", {rr_owner, rr_l2_we}); end
    checks++; if (rr_l2_addr !== 32'h0000_0F40) begin failures++; $display("FAIL refill_addr got=%0h exp=f40", rr_l2_addr); end
    checks++; if ({rr_i_miss, rr_d_miss} !== 2'b11) begin failures++; $display("FAIL refill_miss0 got=%0h exp=3", {rr_i_miss, rr_d_miss}); end
    tick(); #1;
    checks++; if ({rr_owner, rr_i_miss} !== 3'b101) begin failures++; $display("FAIL refill_c1 got=%0h exp=5", {rr_owner, rr_i_miss}); end
    tick(); l2_miss = 1'b0; #1;
    checks++; if ({rr_i_miss, rr_d_miss} !== 2'b10) begin failures++; $display("FAIL refill_done got=%0h exp=2", {rr_i_miss, rr_d_miss}); end
    tick(); d_req = 1'b0; #1;
    checks++; if (rr_owner !== 2'b01) begin failures++; $display("FAIL wb_i_grant got=%0h exp=1", rr_owner); end
    checks++; if (rr_l2_addr !== 32'h0000_0300) begin failures++; $display("FAIL wb_i_addr got=%0h exp=300", rr_l2_addr); end
    tick(); i_req = 1'b0; #1;
  endtask

  task automatic test_hold_timeout();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_2F80; i_req = 1'b1; i_addr = 32'h0000_0400; l2_miss = 1'b0; #1;
    checks++; if (rr_owner !== 2'b10) begin failures++; $display("FAIL hold_c0_owner got=%0h exp=2", rr_owner); end
    tick(); d_req = 1'b0; d_we = 1'b0; l2_miss = 1'b1; #1;
    checks++; if ({rr_owner, rr_i_miss} !== 3'b101) begin failures++; $display("FAIL hold_c1 got=%0h exp=5", {rr_owner, rr_i_miss}); end
    tick(); #1;
    checks++; if ({rr_owner, rr_i_miss} !== 3'b101) begin failures++; $display("FAIL hold_c2 got=%0h exp=5", {rr_owner, rr_i_miss}); end
    tick(); l2_miss = 1'b0; #1;
    checks++; if (rr_owner !== 2'b01) begin failures++; $display("FAIL hold_drop_owner got=%0h exp=1", rr_owner); end
    checks++; if (rr_l2_addr !== 32'h0000_0400) begin failures++; $display("FAIL hold_drop_addr got=%0h exp=400", rr_l2_addr); end
    tick(); i_req = 1'b0; #1;
  endtask

  task automatic test_reset_mid();
    d_req = 1'b1; d_addr = 32'h0000_0500; i_req = 1'b1; i_addr = 32'h0000_0600; l2_miss = 1'b1; #1;
    checks++; if (rr_owner !== 2'b10) begin failures++; $display("FAIL mid_owner got=%0h exp=2", rr_owner); end
    tick(); #1;
    checks++; if (rr_cnt !== 32'd5) begin failures++; $display("FAIL mid_cnt5 got=%0d exp=5", rr_cnt); end
    reset = 1'b0; #1;
    checks++; if ({rr_l2_req, rr_owner} !== 3'b000) begin failures++; $display("FAIL mid_rst_req_owner got=%0h exp=0", {rr_l2_req, rr_owner}); end
    checks++; if (rr_cnt !== 32'd0) begin failures++; $display("FAIL mid_rst_cnt got=%0d exp=0", rr_cnt); end
    checks++; if ({rr_i_miss, rr_d_miss} !== 2'b00) begin failures++; $display("FAIL mid_rst_miss got=%0h exp=0", {rr_i_miss, rr_d_miss}); end
    tick(); tick(); reset = 1'b1; #1;
    checks++; if (rr_owner !== 2'b01) begin failures++; $display("FAIL post_rst_owner got=%0h exp=1", rr_owner); end
    checks++; if ({rr_l2_req, rr_d_miss} !== 2'b11) begin failures++; $display("FAIL post_rst_req got=%0h exp=3", {rr_l2_req, rr_d_miss}); end
    tick(); idle_inputs(); #1;
  endtask

  // Test sequence.
  initial begin
    checks = 0;
    failures = 0;
    l2_rd = '0;
    test_reset();
    test_i_only();
    test_rr_conflict();
    test_fixed_conflict();
    test_writeback_lock();
    test_hold_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l2_port_arbiter.md
Name: l2_port_arbiter

Overview:
- Shares the single L2/memory port between the I-cache and D-cache miss engines of the scalar core.
- Each cache drives its normal mem_req/mem_we/address/block interface and sees a mem_miss stall.
- The arbiter grants one cache at a time and forwards its request with zero added latency.
- A write-back followed by its refill is kept atomic by holding the grant across both.

Parameters:
- BLOCKS, 4, 32-bit words per cache line (matches cache BLOCKS).
- ARB_MODE, 0, 0 = round-robin between I and D; 1 = fixed priority to D.
- HOLD_CYCLES, 2, consecutive idle owner cycles tolerated after a write-back before the lock is dropped.

Ports:
- clock  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- i_mem_req  in  1  I-cache memory request
- i_mem_we  in  1  I-cache write (write-back)
- i_mem_addr  in  32  I-cache line address
- i_mem_write_block  in  BLOCKS*32  I-cache eviction data
- i_mem_read_block  out  BLOCKS*32  refill data to I-cache
- i_mem_miss  out  1  stall/not-done to I-cache
- d_mem_req, d_mem_we, d_mem_addr, d_mem_write_block  in  1/1/32/BLOCKS*32  D-cache equivalents
- d_mem_read_block  out  BLOCKS*32  refill data to D-cache
- d_mem_miss  out  1  stall/not-done to D-cache
- l2_req  out  1  forwarded request
- l2_we  out  1  forwarded write enable
- l2_addr  out  32  forwarded address
- l2_write_block  out  BLOCKS*32  forwarded write data
- l2_read_block  in  BLOCKS*32  L2 read data
- l2_miss  in  1  L2 not-done/stall
- owner  out  2  00 none, 01 I, 10 D (debug)
- conflict_cnt  out  32  cycles with both requests high; saturates at 2^32-1

Behaviour:
- Registered state: FSM state, last_grant (1 bit), hold counter, conflict_cnt.
- FSM states: IDLE, OWN_I, OWN_D, LOCK_I, LOCK_D.
- Reset (reset low, async): state=IDLE; last_grant=D, so I wins the first RR conflict; hold counter=0; conflict_cnt=0.
- Combinational outputs follow from those register values; during reset l2_req=0, l2_we=0, l2_addr=0, l2_write_block=0.
- Winner in IDLE:
  - Sole requester wins.
  - On conflict, ARB_MODE=1 picks D; ARB_MODE=0 picks the requester opposite last_grant.
- Effective owner: IDLE uses the winner in the same cycle (no bubble); OWN_x/LOCK_x use x.
- Forwarding: l2_req/we/addr/write_block = owner's inputs; all zero when there is no owner.
- l2_read_block is broadcast to both i_mem_read_block and d_mem_read_block.
- Stall outputs:
  - Owner's mem_miss = l2_miss.
  - Non-owner's mem_miss = 1 if its req is high, else 0.
  - With no owner, both mem_miss = 0.
- Completion: owner req high and l2_miss low on a clock edge.
- Transitions:
  - IDLE with a winner -> OWN_winner, even if completion happens the same cycle; then apply the OWN_x rules below in that cycle.
  - OWN_x, completion with we=0 -> IDLE; last_grant=x.
  - OWN_x, completion with we=1 -> LOCK_x; hold counter=0.
  - OWN_x, owner req low -> IDLE; last_grant unchanged.
  - LOCK_x behaves as OWN_x (refill read expected).
  - LOCK_x, read completion -> IDLE; last_grant=x.
  - LOCK_x, another write completion -> stay in LOCK_x.
  - LOCK_x, owner req low -> hold counter++; at HOLD_CYCLES -> IDLE, last_grant=x.
  - LOCK_x, owner req high -> hold counter cleared.
- A request from the non-owner never preempts the owner. In RR mode, worst-case wait is one full transaction pair.
- conflict_cnt increments on every clock edge where i_mem_req and d_mem_req are both high.
- Reset mid-transaction aborts immediately to IDLE. L2 sees l2_req drop; both caches re-request after reset.

Decomposition:
- Package l2_arb_pkg:
  - arb_state_t enum (IDLE, OWN_I, OWN_D, LOCK_I, LOCK_D).
  - owner_t encoding (NONE=2'b00, I=2'b01, D=2'b10).
  - ARB_RR=0 and ARB_FIXED_D=1 constants.
  - Line-block typedef parameterised by BLOCKS.
- One combinational sub-module, l2_arb_pick: inputs i_req, d_req, last_grant, mode; output winner owner_t.

Test Plan:
- I-only read miss, l2_miss high 3 cycles -> l2_addr=i_mem_addr in cycle 0; i_mem_miss=1,1,1,0; d_mem_miss=0; owner 01 then 00; last_grant=I.
- Simultaneous I and D read reqs after reset, ARB_MODE=0 -> I served first (conflict_cnt counts each overlap cycle, d_mem_miss held 1), then D served; a repeat conflict grants D first.
- Same conflict with ARB_MODE=1 -> D served first on both rounds.
- D write-back 0x0000_1F40 (we=1, 2-cycle L2), req low 1 cycle, then refill read 0x0000_0F40 while I requests -> D retains LOCK_D, I stalled until the D read completes.
- D write completes, then D req stays low 2 cycles (HOLD_CYCLES=2) -> lock drops, pending I request granted on the next cycle.
- Assert reset mid-OWN_D with l2_miss=1 -> l2_req=0 and owner=00 immediately; conflict_cnt=0; normal arbitration resumes after reset is released.
